fifo_pixel_reader: RTL and testbench
====================================

Name: fifo_pixel_reader

Overview:
- Read-side consumer of the first-word-fall-through asynchronous FIFO, in the FIFO read-clock domain.
- Drains pixel words from the FIFO and emits a timed video stream (de/hs/vs/pixel) toward the DSI packetiser.
- Owns the line/frame counters, the FIFO read strobe, prefill gating, and underrun detection and recovery.

Parameters:
- DW, 24, pixel / FIFO data width.
- H_ACT, 480, active pixels per line.
- H_BLANK, 40, blanking pixels per line (H_TOTAL = H_ACT + H_BLANK).
- HS_W, 8, hs pulse width in clocks, starting at h_cnt = H_ACT; HS_W <= H_BLANK.
- V_ACT, 800, active lines per frame.
- V_BLANK, 20, blanking lines per frame (V_TOTAL = V_ACT + V_BLANK).
- FILL, 24'h0000FF, pixel value driven during underrun.

Ports:
- r_clk  in  1  read-domain clock.
- r_rst  in  1  asynchronous reset, active-high.
- en  in  1  run request; sampled only at a frame boundary.
- r_data  in  DW  FIFO head word, valid while r_empty = 0.
- r_empty  in  1  FIFO empty.
- r_aempty  in  1  FIFO almost empty (at most one word).
- r_re  out  1  FIFO read strobe, combinational.
- pix  out  DW  output pixel, registered.
- de  out  1  data enable, registered.
- hs  out  1  line sync pulse, registered.
- vs  out  1  frame sync, registered; high for the whole of line v_cnt = V_ACT.
- underrun  out  1  sticky underrun flag; cleared at the next frame start.
- urun_cnt  out  16  underrun pixel count for the current frame; saturates at 16'hFFFF.

Behaviour:
- Reset state (async, while r_rst = 1): pix = 0, de = hs = vs = 0, underrun = 0, urun_cnt = 0, h_cnt = v_cnt = 0, state IDLE. Reset mid-frame aborts the frame immediately; the next frame starts fresh from IDLE.
- States:
  - IDLE: counters held at 0, r_re = 0. Go to PREFILL when en = 1.
  - PREFILL: counters held, r_re = 0. Go to RUN when r_aempty = 0, i.e. at least two words buffered. Go back to IDLE if en = 0.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps. On wrap, v_cnt increments and wraps 0..V_TOTAL-1. At the last clock of a frame (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1):
    - en = 0 -> IDLE;
    - en = 1 and r_aempty = 1 -> PREFILL;
    - otherwise stay in RUN.
- Active window: act = RUN and h_cnt < H_ACT and v_cnt < V_ACT.
  - r_re = act & !r_empty; the FIFO word is consumed in the same cycle it is presented (FWFT).
- Output register, one-clock latency from the counter state:
  - de <= act;
  - pix <= act ? (r_empty ? FILL : r_data) : 0;
  - hs <= RUN and H_ACT <= h_cnt < H_ACT + HS_W;
  - vs <= RUN and v_cnt = V_ACT.
- Underrun:
  - Condition: act & r_empty. Then underrun <= 1 and urun_cnt increments (saturating).
  - No word is consumed and h_cnt still advances. Pixels are dropped, never stalled, so timing stays fixed.
- Frame start (first RUN cycle with h_cnt = v_cnt = 0): underrun and urun_cnt clear to 0. If that same cycle underruns, the clear wins and then counts 1.
- en deasserted mid-frame: the current frame completes; en is only sampled at the frame boundary.
- Counter widths are the ceiling of log2 of H_TOTAL and V_TOTAL. Comparisons are unsigned; there is no wrap past TOTAL-1.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE = 0, PREFILL = 1, RUN = 2;
  - a function returning the counter width from a total;
  - the FILL default.
- One sub-module, vid_timing_cnt: h/v counters with enable and synchronous clear. It outputs h_cnt, v_cnt, line_end and frame_end, and is parameterised by H_TOTAL and V_TOTAL.

Test Plan:
- Bench parameters: H_ACT = 4, H_BLANK = 2, HS_W = 1, V_ACT = 2, V_BLANK = 1.
- Nominal frame: preload 8 words 1..8, en = 1 -> RUN one clock after r_aempty falls; de high for 4 clocks per line; pix sequence 1,2,3,4 then 5,6,7,8; hs one clock after each 4th pixel; vs high for line 2; underrun = 0.
- Underrun: preload 5 words, en = 1 -> pix 1..5, then FILL for 3 pixels; underrun = 1, urun_cnt = 3; r_re never asserted while r_empty = 1.
- Prefill gate: en = 1 with 1 word in the FIFO -> stays in PREFILL, de = 0, r_re = 0. Write a 2nd word -> RUN next clock and the first pixel = word 1.
- Mid-frame disable: drop en at pixel 3 of frame 1 -> frame completes with all 8 de pixels, then IDLE; de and r_re stay 0.
- Async reset: assert r_rst mid-line with no clock edge -> all outputs 0 immediately. Release with en = 1 and 8 words present -> a new frame starts at h_cnt = 0 and underrun = 0.
- Saturation: force urun_cnt to 16'hFFFE via a long underrun run with large H_ACT -> it holds at 16'hFFFF; the next frame start clears it to 0.

Source files
------------

// File: rtl/fifo_pixel_reader_pkg.sv
// Shared definitions for the FIFO pixel reader: state encoding, counter
// width helper and the default underrun fill colour.
package fifo_pixel_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2
    } state_e;

    // Pure blue, chosen so dropped pixels are obvious on a panel.
    localparam logic [23:0] FILL_DEFAULT = 24'h0000FF;

    // Bits needed to count 0..total-1; never less than one bit.
    function automatic int cnt_width(input int total);
        return (total > 2) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with run enable and synchronous clear.
// Flags the last clock of each line and of each frame.
module vid_timing_cnt
    import fifo_pixel_reader_pkg::*;
#(
    parameter int H_TOTAL = 520,
    parameter int V_TOTAL = 820,
    parameter int HW      = cnt_width(H_TOTAL),
    parameter int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          line_end_o,
    output logic          frame_end_o
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          line_end;
    logic          frame_end;

    assign line_end  = (h_cnt_q == H_LAST);
    assign frame_end = line_end && (v_cnt_q == V_LAST);

    // Next raster position: clear dominates, otherwise advance while enabled.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clr_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (en_i) begin
            if (line_end) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign line_end_o  = line_end;
    assign frame_end_o = frame_end;

endmodule

// File: rtl/fifo_pixel_reader.sv
// Read-side consumer of a first-word-fall-through FIFO. Drains pixels into a
// fixed-timing de/hs/vs/pixel stream; underruns substitute FILL rather than
// stalling, so raster timing never moves.
module fifo_pixel_reader
    import fifo_pixel_reader_pkg::*;
#(
    parameter int             DW      = 24,
    parameter int             H_ACT   = 480,
    parameter int             H_BLANK = 40,
    parameter int             HS_W    = 8,
    parameter int             V_ACT   = 800,
    parameter int             V_BLANK = 20,
    parameter logic [DW-1:0]  FILL    = DW'(FILL_DEFAULT)
) (
    input  logic          r_clk,
    input  logic          r_rst,
    input  logic          en,
    input  logic [DW-1:0] r_data,
    input  logic          r_empty,
    input  logic          r_aempty,
    output logic          r_re,
    output logic [DW-1:0] pix,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic          underrun,
    output logic [15:0]   urun_cnt
);

    localparam int H_TOTAL = H_ACT + H_BLANK;
    localparam int V_TOTAL = V_ACT + V_BLANK;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
    // One extra bit: the hs window may end exactly at H_TOTAL.
    localparam logic [HW:0]   HS_END_C = (HW + 1)'(H_ACT + HS_W);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;
    logic          frame_end;
    logic          cnt_clr;

    logic          run;
    logic          act;
    logic          hs_win;
    logic          vs_win;
    logic          urun_now;
    logic          frame_start;
    logic          re_comb;

    logic          sof_q, sof_d;
    logic [DW-1:0] pix_q;
    logic          de_q, hs_q, vs_q;
    logic          underrun_q, underrun_d;
    logic [15:0]   urun_cnt_q, urun_cnt_d;

    // Counters only move in RUN and sit at zero otherwise, so every RUN entry
    // begins at the top-left of a frame.
    assign cnt_clr = (state_q != RUN);

    vid_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .clk_i       (r_clk),
        .rst_i       (r_rst),
        .en_i        (run),
        .clr_i       (cnt_clr),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    // FSM state register.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; en is only honoured at a frame boundary while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = PREFILL;
            end
            PREFILL: begin
                if (!en)           state_d = IDLE;
                else if (!r_aempty) state_d = RUN;
            end
            RUN: begin
                if (line_end && (v_cnt == V_LAST_C)) begin
                    if (!en)           state_d = IDLE;
                    else if (r_aempty) state_d = PREFILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: active window, FIFO strobe, sync windows, underrun event.
    always_comb begin
        run         = (state_q == RUN);
        act         = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        re_comb     = act && !r_empty;
        urun_now    = act && r_empty;
        hs_win      = run && (h_cnt >= H_ACT_C) && ({1'b0, h_cnt} < HS_END_C);
        vs_win      = run && (v_cnt == V_ACT_C);
        frame_start = run && sof_q;
        sof_d       = !run || frame_end;
    end

    assign r_re = re_comb;

    // Underrun bookkeeping: frame start clears first, a same-cycle underrun
    // then counts on top of the cleared value.
    always_comb begin
        underrun_d = underrun_q;
        urun_cnt_d = urun_cnt_q;
        if (frame_start) begin
            underrun_d = 1'b0;
            urun_cnt_d = '0;
        end
        if (urun_now) begin
            underrun_d = 1'b1;
            if (urun_cnt_d != 16'hFFFF) urun_cnt_d = urun_cnt_d + 16'd1;
        end
    end

    // Registered video outputs and underrun status.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            sof_q      <= 1'b1;
            pix_q      <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            sof_q      <= sof_d;
            pix_q      <= act ? (r_empty ? FILL : r_data) : '0;
            de_q       <= act;
            hs_q       <= hs_win;
            vs_q       <= vs_win;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign pix      = pix_q;
    assign de       = de_q;
    assign hs       = hs_q;
    assign vs       = vs_q;
    assign underrun = underrun_q;
    assign urun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Bench for fifo_pixel_reader: a behavioural FWFT FIFO feeds the DUT and a
// raster-position model predicts each clock's outputs from the pushed words.
module tb_fifo_pixel_reader;

    localparam int DW      = 24;
    localparam int H_ACT   = 4;
    localparam int H_BLANK = 2;
    localparam int HS_W    = 1;
    localparam int V_ACT   = 2;
    localparam int V_BLANK = 1;
    localparam int H_TOTAL = H_ACT + H_BLANK;
    localparam int V_TOTAL = V_ACT + V_BLANK;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam logic [DW-1:0] FILL = 24'h0000FF;

    // Large raster for the saturation scenario.
    localparam int S_HACT  = 258;
    localparam int S_HTOT  = 259;
    localparam int S_VACT  = 256;
    localparam int S_FRAME = 259 * 257;

    int n_tests = 0;
    int n_fail  = 0;

    logic          r_clk = 1'b0;
    logic          r_rst = 1'b1;
    logic          en    = 1'b0;
    logic [DW-1:0] r_data;
    logic          r_empty, r_aempty, r_re;
    logic [DW-1:0] pix;
    logic          de, hs, vs, underrun;
    logic [15:0]   urun_cnt;

    always #5 r_clk = ~r_clk;

    // Behavioural FWFT FIFO.
    logic [DW-1:0] fifo_mem [0:255];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic [DW-1:0] exp_q [$];

    assign r_data   = fifo_mem[rd_ptr[7:0]];
    assign r_empty  = (wr_ptr == rd_ptr);
    assign r_aempty = ((wr_ptr - rd_ptr) <= 1);

    always @(posedge r_clk) if (r_re) rd_ptr <= rd_ptr + 1;

    fifo_pixel_reader #(
        .DW(DW), .H_ACT(H_ACT), .H_BLANK(H_BLANK), .HS_W(HS_W),
        .V_ACT(V_ACT), .V_BLANK(V_BLANK), .FILL(FILL)
    ) dut (
        .r_clk(r_clk), .r_rst(r_rst), .en(en), .r_data(r_data),
        .r_empty(r_empty), .r_aempty(r_aempty), .r_re(r_re), .pix(pix),
        .de(de), .hs(hs), .vs(vs), .underrun(underrun), .urun_cnt(urun_cnt)
    );

    // Second instance and word counter for the saturation scenario.
    logic          s_rst = 1'b1;
    logic          s_en  = 1'b0;
    logic [DW-1:0] s_data = 24'h00AA55;
    logic          s_empty, s_aempty, s_re;
    logic [DW-1:0] s_pix;
    logic          s_de, s_hs, s_vs, s_underrun;
    logic [15:0]   s_urun_cnt;
    int unsigned   s_wr = 0;
    int unsigned   s_rd = 0;

    assign s_empty  = (s_wr == s_rd);
    assign s_aempty = ((s_wr - s_rd) <= 1);

    always @(posedge r_clk) if (s_re) s_rd <= s_rd + 1;

    fifo_pixel_reader #(
        .DW(DW), .H_ACT(S_HACT), .H_BLANK(1), .HS_W(1),
        .V_ACT(S_VACT), .V_BLANK(1), .FILL(FILL)
    ) dut_sat (
        .r_clk(r_clk), .r_rst(s_rst), .en(s_en), .r_data(s_data),
        .r_empty(s_empty), .r_aempty(s_aempty), .r_re(s_re), .pix(s_pix),
        .de(s_de), .hs(s_hs), .vs(s_vs), .underrun(s_underrun), .urun_cnt(s_urun_cnt)
    );

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        r_rst = 1'b1;
        en    = 1'b0;
        flush();
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    // Runs from IDLE (or PREFILL with from_prefill) and compares every clock
    // against the raster model. Step k is the k-th RUN clock of the frame;
    // registered outputs seen at step k belong to step k-1.
    task automatic run_check(input string name, input int ncyc, input int drop_at,
                             input bit from_prefill, input int cnt0);
        int h, v, cnt;
        bit act, e_re, p_de, p_hs, p_vs;
        logic [DW-1:0] p_pix;
        cnt = cnt0; p_pix = '0; p_de = 0; p_hs = 0; p_vs = 0;
        en = 1'b1;
        if (!from_prefill) @(posedge r_clk);
        @(posedge r_clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge r_clk);
            h    = k % H_TOTAL;
            v    = k / H_TOTAL;
            act  = (k < FRAME) && (h < H_ACT) && (v < V_ACT);
            e_re = act && (exp_q.size() > 0);
            n_tests++;
            if (r_re !== e_re) begin
                n_fail++;
                $display("FAIL %s r_re step %0d: got %b want %b", name, k, r_re, e_re);
            end
            n_tests++;
            if (de !== p_de) begin
                n_fail++;
                $display("FAIL %s de step %0d: got %b want %b", name, k, de, p_de);
            end
            n_tests++;
            if (pix !== p_pix) begin
                n_fail++;
                $display("FAIL %s pix step %0d: got %h want %h", name, k, pix, p_pix);
            end
            n_tests++;
            if (hs !== p_hs || vs !== p_vs) begin
                n_fail++;
                $display("FAIL %s hs/vs step %0d: got %b/%b want %b/%b", name, k, hs, vs, p_hs, p_vs);
            end
            n_tests++;
            if (underrun !== (cnt > 0) || urun_cnt !== 16'(cnt)) begin
                n_fail++;
                $display("FAIL %s underrun step %0d: got %b/%0d want %b/%0d",
                         name, k, underrun, urun_cnt, (cnt > 0), cnt);
            end
            if (k == 0) cnt = 0;
            if (act) begin
                if (exp_q.size() > 0) p_pix = exp_q.pop_front();
                else begin p_pix = FILL; cnt++; end
            end else begin
                p_pix = '0;
            end
            p_de = act;
            p_hs = (k < FRAME) && (h >= H_ACT) && (h < H_ACT + HS_W);
            p_vs = (k < FRAME) && (v == V_ACT);
            if (k == drop_at) en = 1'b0;
        end
        $display("[TB] %s: %0d steps, urun_cnt=%0d", name, ncyc, urun_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        n_tests++;
        if ({pix, de, hs, vs, underrun, urun_cnt, r_re} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got pix=%h de=%b hs=%b vs=%b ur=%b cnt=%0d re=%b want all 0",
                     pix, de, hs, vs, underrun, urun_cnt, r_re);
        end
        r_rst = 1'b0;
        push(24'h123456); push(24'h654321);
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            n_tests++;
            if (de !== 1'b0 || r_re !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold: got de=%b re=%b want 0/0", de, r_re);
            end
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_nominal();
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        run_check("nominal", FRAME + 1, -1, 1'b0, 0);
    endtask

    task automatic test_underrun();
        do_reset();
        for (int i = 1; i <= 5; i++) push(DW'(i));
        run_check("underrun", FRAME + 1, -1, 1'b0, 0);
        n_tests++;
        if (underrun !== 1'b1 || urun_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL underrun_total: got %b/%0d want 1/3", underrun, urun_cnt);
        end
        // Next frame start must clear the sticky status.
        for (int i = 0; i < 8; i++) push(DW'($urandom_range(24'hFFFFFF, 0)));
        run_check("underrun_clear", FRAME + 1, -1, 1'b1, 3);
    endtask

    task automatic test_prefill_gate();
        do_reset();
        push(24'd1);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge r_clk);
            n_tests++;
            if (de !== 1'b0 || r_re !== 1'b0 || pix !== '0) begin
                n_fail++;
                $display("FAIL prefill_hold: got de=%b re=%b pix=%h want 0/0/0", de, r_re, pix);
            end
        end
        push(24'd2);
        run_check("prefill_gate", FRAME + 1, -1, 1'b1, 0);
    endtask

    task automatic test_mid_disable();
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        run_check("mid_disable", FRAME + 4, 2, 1'b0, 0);
        push(24'hABCDEF); push(24'hFEDCBA);
        for (int i = 0; i < 4; i++) begin
            @(negedge r_clk);
            n_tests++;
            if (de !== 1'b0 || r_re !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_idle: got de=%b re=%b want 0/0", de, r_re);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        en = 1'b1;
        repeat (4) @(posedge r_clk);
        #2;
        r_rst = 1'b1;
        #1;
        n_tests++;
        if ({pix, de, hs, vs, underrun, urun_cnt, r_re} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got pix=%h de=%b re=%b want all 0", pix, de, r_re);
        end
        repeat (2) @(posedge r_clk);
        flush();
        for (int i = 0; i < 8; i++) push(DW'($urandom_range(24'hFFFFFF, 0)));
        @(negedge r_clk);
        r_rst = 1'b0;
        run_check("after_async_reset", FRAME + 1, -1, 1'b0, 0);
    endtask

    task automatic test_random();
        int n, drop;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            n = int'($urandom_range(8, 2));
            for (int i = 0; i < n; i++) push(DW'($urandom_range(24'hFFFFFF, 0)));
            drop = ($urandom_range(1, 0) == 1) ? int'($urandom_range(FRAME - 1, 0)) : -1;
            run_check("random", FRAME + 2, drop, 1'b0, 0);
        end
    endtask

    task automatic test_saturation();
        int h, v, raw, words;
        bit act, seen_fe;
        raw = 0; words = 2; seen_fe = 0;
        s_wr = s_wr + 2;
        @(negedge r_clk);
        s_rst = 1'b0;
        s_en  = 1'b1;
        @(posedge r_clk);
        @(posedge r_clk);
        for (int k = 0; k <= S_FRAME + 1; k++) begin
            @(negedge r_clk);
            if (!seen_fe && raw == 65534) begin
                seen_fe = 1;
                n_tests++;
                if (s_urun_cnt !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL sat_fffe step %0d: got %h want fffe", k, s_urun_cnt);
                end
            end
            if (k == S_FRAME - 1) begin
                n_tests++;
                if (s_urun_cnt !== 16'hFFFF || s_underrun !== 1'b1 || raw <= 65535) begin
                    n_fail++;
                    $display("FAIL sat_hold: got %h/%b want ffff/1 (raw %0d)", s_urun_cnt, s_underrun, raw);
                end
            end
            if (k == S_FRAME + 1) begin
                n_tests++;
                if (s_urun_cnt !== 16'h0000 || s_underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_clear: got %h/%b want 0000/0", s_urun_cnt, s_underrun);
                end
            end
            if (k == S_FRAME) raw = 0;
            h   = k % S_HTOT;
            v   = (k % S_FRAME) / S_HTOT;
            act = (h < S_HACT) && (v < S_VACT);
            if (act) begin
                if (words > 0) words--;
                else raw++;
            end
            if (k == S_VACT * S_HTOT + 3) begin
                s_wr  = s_wr + 2;
                words = words + 2;
            end
        end
        s_en  = 1'b0;
        s_rst = 1'b1;
        $display("[TB] saturation: done, urun_cnt=%h", s_urun_cnt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_underrun();
        test_prefill_gate();
        test_mid_disable();
        test_async_reset();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
